// File: rtl/sine_arb_pkg.sv
// Shared constants and the response tag type for the sine ROM arbiter.
// Optional build macro SINE_ARB_FIXED_PRIO_EN is consumed by sine_rom_arbiter.
package sine_arb_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int MAX_REQ    = 8;
  localparam int IDX_W      = $clog2(MAX_REQ);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/sine_arb_rr_pick.sv
// Rotating-priority pick: the first requester above ptr, wrapping.
// Output is the one-hot winner, its index, and whether anyone requested.
module sine_arb_rr_pick
  import sine_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int best_d;
  int d;

  // Distance from ptr runs 1..N, so ptr itself has the lowest priority.
  always_comb begin
    winner = '0;
    idx    = '0;
    any    = 1'b0;
    best_d = N + 1;
    d      = 0;
    for (int i = 0; i < N; i++) begin
      d = (i > int'(ptr)) ? (i - int'(ptr)) : (i + N - int'(ptr));
      if (req[i] && (d < best_d)) begin
        best_d = d;
        idx    = IDX_W'(i);
        any    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      winner[i] = any && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/sine_rom_arbiter.sv
// Arbitrates NUM_REQ requesters onto one sine ROM port and routes the data back.
// Define SINE_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module sine_rom_arbiter
  import sine_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ROM_LAT = 1,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_ena,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data
);

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               win_any;
  logic               grant_ok;
  tag_t               pipe [ROM_LAT];
  tag_t               tail;

`ifdef SINE_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest requesting index is the one left standing.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_idx   = IDX_W'(i);
        win_any   = 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr;

  sine_arb_rr_pick #(
    .N(NUM_REQ)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .winner(win_oh),
    .idx   (win_idx),
    .any   (win_any)
  );

  // Reset value makes requester 0 the first winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDX_W'(NUM_REQ - 1);
    end else if (grant_ok) begin
      ptr <= win_idx;
    end
  end
`endif

  // Grants are suppressed while reset is held so nothing leaks out mid-reset.
  assign grant_ok = en && win_any && !rst;
  assign gnt      = grant_ok ? win_oh : '0;
  assign rom_ena  = grant_ok;

  always_comb begin
    rom_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        rom_addr = addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Tag pipeline matches the ROM latency so each response finds its owner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < ROM_LAT; k++) begin
        pipe[k] <= '0;
      end
    end else begin
      pipe[0] <= '{valid: grant_ok, idx: win_idx};
      for (int k = 1; k < ROM_LAT; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

  assign tail     = pipe[ROM_LAT-1];
  assign rsp_data = rom_data;

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = tail.valid && (tail.idx == IDX_W'(i));
    end
  end

endmodule

// File: doc/sine_rom_arbiter.md
SINE_ROM_ARBITER -- requirements
Module: sine_rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (legal 2..8).
REQ-002 SHALL have parameter ROM_LAT, default 1, sine ROM read latency in clocks (legal 1..2).
REQ-003 SHALL have parameter ADDR_W, default 16, ROM address width.
REQ-004 SHALL have parameter DATA_W, default 16, ROM sample width.
REQ-005 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port en  input  1  global enable; 0 blocks new grants.
REQ-008 SHALL have port req  input  NUM_REQ  per-requester read request.
REQ-009 SHALL have port addr  input  NUM_REQ*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port gnt  output  NUM_REQ  one-hot grant, combinational, same cycle as accepted req.
REQ-011 SHALL have port rom_ena  output  1  ROM enable.
REQ-012 SHALL have port rom_addr  output  ADDR_W  ROM address.
REQ-013 SHALL have port rom_data  input  DATA_W  ROM read data.
REQ-014 SHALL have port rsp_valid  output  NUM_REQ  one-hot, marks rsp_data as belonging to requester i.
REQ-015 SHALL have port rsp_data  output  DATA_W  shared response data bus.

Function
REQ-016 Transfer SHALL occur when req[i] & gnt[i]; requester holds req[i] and addr slice stable until granted.
REQ-017 At most one gnt bit SHALL be high per cycle; gnt SHALL be all-zero when en=0 or req=0.
REQ-018 Winner SHALL be the first requesting index searching upward from (ptr+1) mod NUM_REQ, wrapping.
REQ-019 ptr SHALL load the winner index on a grant cycle and hold otherwise.
REQ-020 On a grant cycle rom_ena SHALL be 1 and rom_addr the winner's address; otherwise rom_ena=0, rom_addr=0.
REQ-021 A grant SHALL be possible every cycle (back-to-back, full throughput, no bubbles).
REQ-022 A ROM_LAT-deep tag pipeline (valid + index) SHALL track each grant; rsp_valid[idx] SHALL assert exactly ROM_LAT cycles after the grant cycle, for one cycle.
REQ-023 rsp_data SHALL equal rom_data unregistered in the rsp_valid cycle; value is don't-care when rsp_valid=0.
REQ-024 Deasserting en SHALL not cancel in-flight reads; their responses still emerge.
REQ-025 req deasserted before grant SHALL be dropped with no response and no ptr change.

Reset
REQ-026 On rst: gnt=0, rom_ena=0, rom_addr=0, rsp_valid=0, tag pipeline cleared, ptr=NUM_REQ-1 (requester 0 wins first).
REQ-027 Reads in flight at reset SHALL produce no response; first grant possible the first cycle rst is low.

Configuration
REQ-028 Macro SINE_ARB_FIXED_PRIO_EN: when defined, winner SHALL be the lowest requesting index and ptr is not implemented; when undefined, round-robin per REQ-018/019.

Structure
REQ-029 Package sine_arb_pkg SHALL hold default ADDR_W/DATA_W constants, MAX_REQ=8, and the tag struct type (valid, index).
REQ-030 Sub-module sine_arb_rr_pick SHALL implement the combinational rotating priority pick (req, ptr -> one-hot winner, index, any).

Verification (NUM_REQ=3, ROM_LAT=1, ROM modelled as data=addr+0x100)
REQ-031 After reset, req=3'b111 held 6 cycles, addr0/1/2=0x10/0x20/0x30 -> gnt 001,010,100,001,010,100; rsp_valid one cycle later each, rsp_data 0x110,0x120,0x130 repeating.
REQ-032 req=3'b010 only, 4 cycles -> gnt=010 each cycle, rom_ena=1 all 4 cycles, 4 responses to requester 1.
REQ-033 Grant to req2 in cycle N, en=0 from N+1 -> rsp_valid=100 in N+1, gnt=0 thereafter, rom_ena=0.
REQ-034 rst asserted asynchronously mid-cycle right after a grant -> rsp_valid stays 0, rom_ena=0 immediately; after release req=3'b110 -> req1 granted first.
REQ-035 ROM_LAT=2 rebuild, req0 addr 0x05 single grant -> rsp_valid=001 exactly 2 cycles later, rsp_data=0x105.
REQ-036 SINE_ARB_FIXED_PRIO_EN defined, req=3'b111 held 3 cycles -> gnt=001 every cycle.
